// File: rtl/seg7_capture.sv
// Recovers digit codes from a multiplexed active-high 7-segment bus, debounces
// each digit and presents a full frame of codes on a valid/ready interface.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     digit_sel,
  output logic [4*NUM_DIGITS-1:0]   bcd_out,
  output logic [NUM_DIGITS-1:0]     err_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      bad_pattern
);

  typedef enum logic {COLLECT, PRESENT} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Returns {legal, err, code}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 6'b10_0000;
      7'b0110000: decode = 6'b10_0001;
      7'b1101101: decode = 6'b10_0010;
      7'b1111001: decode = 6'b10_0011;
      7'b0110011: decode = 6'b10_0100;
      7'b1011011: decode = 6'b10_0101;
      7'b1011111: decode = 6'b10_0110;
      7'b1110000: decode = 6'b10_0111;
      7'b1111111: decode = 6'b10_1000;
      7'b1111011: decode = 6'b10_1001;
      7'b1001111: decode = 6'b11_1110;
      default:    decode = 6'b00_0000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] r);
    sat_inc = (r >= STABLE) ? STABLE : r + 8'd1;
  endfunction

  state_t                    state;
  logic [NUM_DIGITS-1:0]     sel_p1;
  logic [6:0]                seg_p1;
  logic [7:0]                run_len;
  logic [NUM_DIGITS-1:0]     captured;
  logic [4*NUM_DIGITS-1:0]   code_p1;
  logic [NUM_DIGITS-1:0]     err_p1;

  logic                      onehot;
  logic                      match;
  logic [7:0]                run_nxt;
  logic                      accept;
  logic [5:0]                dec;
  logic                      acc_legal;
  logic                      acc_bad;
  logic [NUM_DIGITS-1:0]     set_mask;

  // Stage p0: run tracking and acceptance on the incoming sample
  always_comb begin
    onehot    = $onehot(digit_sel);
    match     = onehot && ({digit_sel, seg_in} == {sel_p1, seg_p1});
    run_nxt   = !onehot ? 8'd0 : (match ? sat_inc(run_len) : 8'd1);
    // A saturated run must not re-accept; a restart may accept when STABLE is 1.
    accept    = onehot && (run_nxt == STABLE) && (!match || (run_len != STABLE));
    dec       = decode(seg_in);
    acc_legal = accept && dec[5];
    acc_bad   = accept && !dec[5];
    set_mask  = acc_legal ? digit_sel : '0;
  end

  // Stage p1: per-digit code registers, always holding the latest accepted value
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (acc_legal && digit_sel[k]) begin
        code_p1[4*k +: 4] <= dec[3:0];
        err_p1[k]         <= dec[4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1      <= '0;
      seg_p1      <= '0;
      run_len     <= '0;
      captured    <= '0;
      bad_pattern <= 1'b0;
      state       <= COLLECT;
      valid_out   <= 1'b0;
      bcd_out     <= '0;
      err_out     <= '0;
    end else begin
      sel_p1      <= digit_sel;
      seg_p1      <= seg_in;
      run_len     <= run_nxt;
      bad_pattern <= acc_bad;
      captured    <= captured | set_mask;
      case (state)
        COLLECT: begin
          if (&captured) begin
            bcd_out   <= code_p1;
            err_out   <= err_p1;
            valid_out <= 1'b1;
            captured  <= set_mask;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (valid_out && ready_in) begin
            valid_out <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: expected frames are queued by the stimulus,
// a negedge monitor pops and compares them on each accepted handshake.
module tb_seg7_capture;

  localparam int ND = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg_in = '0;
  logic [ND-1:0]   digit_sel = '0;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   err_out;
  logic            valid_out;
  logic            ready_in = 1'b1;
  logic            bad_pattern;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_sel(digit_sel),
    .bcd_out(bcd_out), .err_out(err_out), .valid_out(valid_out),
    .ready_in(ready_in), .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   err;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int bad_seen = 0;
  int bad_exp = 0;
  int vld_cnt = 0;

  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_ILL = 7'b0000001;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'b1111110;
      1: glyph = 7'b0110000;
      2: glyph = 7'b1101101;
      3: glyph = 7'b1111001;
      4: glyph = 7'b0110011;
      5: glyph = 7'b1011011;
      6: glyph = 7'b1011111;
      7: glyph = 7'b1110000;
      8: glyph = 7'b1111111;
      default: glyph = 7'b1111011;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: hold stability, bad_pattern pulses and frame handshakes.
  logic            prev_v = 1'b0;
  logic [4*ND-1:0] prev_bcd = '0;
  logic [ND-1:0]   prev_err = '0;

  always @(negedge clk) begin
    frame_t f;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (valid_out && prev_v) begin
        check("hold_bcd", 32'(bcd_out), 32'(prev_bcd));
        check("hold_err", 32'(err_out), 32'(prev_err));
      end
      if (valid_out) vld_cnt++;
      if (bad_pattern) bad_seen++;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got bcd %0h err %0h, expected no frame", bcd_out, err_out);
        end else begin
          f = exp_q.pop_front();
          check("frame_bcd", 32'(bcd_out), 32'(f.bcd));
          check("frame_err", 32'(err_out), 32'(f.err));
        end
      end
      prev_v   = valid_out;
      prev_bcd = bcd_out;
      prev_err = err_out;
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int k, input logic [6:0] p, input int n);
    digit_sel = ND'(1 << k);
    seg_in    = p;
    cyc(n);
  endtask

  task automatic blank();
    digit_sel = '0;
    seg_in    = '0;
    cyc(1);
  endtask

  task automatic digit(input int k, input int d);
    drive(k, glyph(d), 3);
    blank();
  endtask

  task automatic push(input logic [4*ND-1:0] b, input logic [ND-1:0] e);
    frame_t f;
    f.bcd = b;
    f.err = e;
    exp_q.push_back(f);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      cyc(1);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    cyc(3);
  endtask

  initial begin
    cyc(2);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_bad", 32'(bad_pattern), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Basic frame 4321
    push(16'h4321, 4'b0000);
    digit(0, 1); digit(1, 2); digit(2, 3); digit(3, 4);
    drain();
    check("t1_valid_cycles", 32'(vld_cnt), 32'd1);

    // Debounce: short run of 1 is discarded, then 2 accepted
    push(16'h0002, 4'b0000);
    drive(0, glyph(1), 2);
    drive(0, glyph(2), 3);
    blank();
    digit(1, 0); digit(2, 0); digit(3, 0);
    drain();

    // Error glyph on digit 2
    push(16'h7E77, 4'b0100);
    digit(0, 7); digit(1, 7);
    drive(2, SEG_E, 3); blank();
    digit(3, 7);
    drain();

    // Illegal pattern: one pulse, digit 1 not captured, no frame
    drive(1, SEG_ILL, 5); blank();
    bad_exp++;
    cyc(2);
    check("t4_bad_pulses", 32'(bad_seen), 32'(bad_exp));
    digit(0, 3); digit(2, 3); digit(3, 3);
    cyc(5);
    check("t4_no_frame", 32'(valid_out), 32'd0);
    push(16'h3393, 4'b0000);
    digit(1, 9);
    drain();

    // Backpressure: frame held while new digits arrive, then latest frame follows
    ready_in = 1'b0;
    vld_cnt = 0;
    push(16'h8765, 4'b0000);
    push(16'h2109, 4'b0000);
    digit(0, 5); digit(1, 6); digit(2, 7); digit(3, 8);
    digit(0, 9); digit(1, 0); digit(2, 1); digit(3, 2);
    check("t5_held_valid", 32'(valid_out), 32'd1);
    check("t5_held_bcd", 32'(bcd_out), 32'h8765);
    check("t5_held_long", 32'(vld_cnt >= 10), 32'd1);
    ready_in = 1'b1;
    drain();

    // Reset mid-frame: partial capture discarded
    digit(0, 1); digit(1, 2); digit(2, 3);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_bcd", 32'(bcd_out), 32'd0);
    check("mid_rst_err", 32'(err_out), 32'd0);
    check("mid_rst_bad", 32'(bad_pattern), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1);
    push(16'h7654, 4'b0000);
    digit(3, 7);
    cyc(4);
    check("t6_no_early_frame", 32'(valid_out), 32'd0);
    digit(0, 4); digit(1, 5); digit(2, 6);
    drain();

    check("final_bad_pulses", 32'(bad_seen), 32'(bad_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Recovers digit values from a time-multiplexed, active-high 7-segment display bus, the inverse of our BCD-to-7-segment path. It debounces each digit's segment pattern and encodes it back to a 4-bit code. Once every digit has been captured, it presents the whole frame on a valid/ready interface. The block sits in the display self-check loop, where it taps the same segment and digit-select lines that drive the panel.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CYCLES, 3: consecutive identical samples required to accept a digit (1..255).

- clk  in  1  single clock; everything samples on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment pattern {a,b,c,d,e,f,g}, with a = bit 6 and g = bit 0; 1 = lit.
- digit_sel  in  NUM_DIGITS  one-hot active-high digit select; bit k selects digit k.
- bcd_out  out  4*NUM_DIGITS  captured frame; digit k is in bits [4k+3:4k].
- err_out  out  NUM_DIGITS  bit k = 1 when digit k showed the error glyph.
- valid_out  out  1  frame on bcd_out/err_out is valid.
- ready_in  in  1  consumer accepts the frame.
- bad_pattern  out  1  one-cycle pulse when an accepted pattern is illegal.

## Operation
- Legal patterns map to codes as follows:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4.
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 1001111 (the "E" glyph for inputs 10–15) → code 4'hE, with the err flag set.
  - Every other pattern is illegal.
- Run tracking:
  - The block registers the previous (digit_sel, seg_in) pair.
  - run_len counts consecutive cycles where digit_sel is one-hot and the pair matches the previous sample. It saturates at STABLE_CYCLES.
  - A non-one-hot digit_sel (zero, i.e. blanking, or multi-hot) sets run_len to 0. Any change of the pair restarts run_len at 1.
- Acceptance: exactly once per run, on the sample where run_len reaches STABLE_CYCLES.
  - Legal pattern: write the code and err flag into internal digit register k, and set captured[k].
  - Illegal pattern: no write, captured unchanged, bad_pattern pulses.
  - With STABLE_CYCLES = 1, the first one-hot sample of a run is accepted.
- FSM, two states; reset state is COLLECT.
  - COLLECT: when captured is all ones, load the internal registers into bcd_out/err_out, assert valid_out, clear captured, and go to PRESENT.
  - PRESENT: bcd_out/err_out/valid_out are held stable. Capture continues into the internal registers. When valid_out && ready_in, deassert valid_out and go to COLLECT.
- Simultaneous events:
  - If an acceptance lands on the edge that clears captured, the new bit stays set (set wins).
  - A digit re-accepted before the frame is full overwrites its internal value; the frame always carries the latest value of each digit.
- Reset mid-operation: all state clears immediately. Any partial frame is discarded; no frame is emitted for it.

## Timing
- Reset values: bcd_out = 0, err_out = 0, valid_out = 0, bad_pattern = 0, state COLLECT, captured = 0, run_len = 0.
- Capture latency: a digit is written at the edge sampling its STABLE_CYCLES-th identical cycle.
- Frame output: valid_out rises one edge after the edge that completes captured.
- bad_pattern: high for exactly the one cycle following the accepting edge.
- Handshake:
  - valid_out falls on the edge after valid_out && ready_in are sampled high.
  - ready_in high while valid_out is low has no effect.
- Back-to-back frames: minimum one COLLECT cycle between handshake and the next valid_out, so the valid gap is ≥ 1 cycle.
- Output data never changes while valid_out = 1.

## Test plan
- Defaults, ready_in = 1: drive digits 0..3 with patterns for 1,2,3,4, each for 3 cycles. Required: bcd_out = 16'h4321, err_out = 0, valid_out high for 1 cycle.
- Debounce: hold digit 0 with 0110000 for 2 cycles, change to 1101101 for 3 cycles, then fill the remaining digits with 0. Required: digit 0 = 2, with no capture of 1.
- Error glyph: digit 2 shows 1001111 for 3 cycles, the others show 7. Required: bcd_out = 16'h7E77, err_out = 4'b0100.
- Illegal pattern: digit 1 shows 0000001 for 5 cycles. Required: a single bad_pattern pulse, captured[1] stays 0, and no frame is emitted.
- Backpressure: complete a frame with ready_in = 0 for 10 cycles while re-driving new digits. Required: valid_out and bcd_out are held unchanged. After ready_in = 1, valid_out drops, then the next frame presents the latest values.
- Reset mid-frame: after capturing 3 of 4 digits, pulse rst_n low asynchronously. Required: all outputs are 0 at once, and a frame appears only after 4 fresh captures.
